// File: rtl/ram_wb_pkg.sv
// Shared constants, FSM state type and burst address stepping for the Wishbone RAM slave.
// Cycle-type and burst-type encodings follow Wishbone B3 registered feedback.
package ram_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

  // Wrapping bursts only advance the low bits, so the beat stays inside its aligned block.
  function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
    logic [31:0] inc;
    inc = a + 32'd1;
    case (bte)
      BTE_WRAP4:  next_adr = {a[31:2], inc[1:0]};
      BTE_WRAP8:  next_adr = {a[31:3], inc[2:0]};
      BTE_WRAP16: next_adr = {a[31:4], inc[3:0]};
      default:    next_adr = inc;
    endcase
  endfunction

endpackage

// File: rtl/ram_be.sv
// Synchronous RAM, independent read/write addresses, per-byte write enables.
// One-cycle registered read; output cleared by reset; out-of-range addresses read 0 and never write.
module ram_be #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 10,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADR_WIDTH-1:0]   rd_adr_i,
  input  logic [ADR_WIDTH-1:0]   wr_adr_i,
  input  logic [DAT_WIDTH/8-1:0] we_i,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  output logic [DAT_WIDTH-1:0]   dat_o
);

  localparam int SEL_W = DAT_WIDTH / 8;

  logic [DAT_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DAT_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic                 rd_ok, wr_ok;

  assign rd_ok = 32'(rd_adr_i) < 32'(MEM_SIZE);
  assign wr_ok = 32'(wr_adr_i) < 32'(MEM_SIZE);

  always_comb begin
    rd_dat_d = '0;
    if (rd_ok) rd_dat_d = mem_q[rd_adr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_dat_q <= '0;
    else       rd_dat_q <= rd_dat_d;
    if (wr_ok) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (we_i[b]) mem_q[wr_adr_i][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
  end

  assign dat_o = rd_dat_q;

endmodule

// File: rtl/ram_wb_burst.sv
// Wishbone B3 RAM slave: classic, incrementing and wrapping bursts, bus error past MEM_SIZE.
// Ack one cycle after strobe, then one beat per clock; dropping stb ends the burst and restarts it later.
module ram_wb_burst #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 10,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  output logic [DAT_WIDTH-1:0]   dat_o,
  input  logic [ADR_WIDTH-1:0]   adr_i,
  input  logic                   we_i,
  input  logic [DAT_WIDTH/8-1:0] sel_i,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic [2:0]             cti_i,
  input  logic [1:0]             bte_i,
  output logic                   ack_o,
  output logic                   err_o
);

  import ram_wb_pkg::*;

  localparam int SEL_W = DAT_WIDTH / 8;

  state_t               state_q, state_d;
  logic                 ack_q, ack_d, err_q, err_d;
  logic [ADR_WIDTH-1:0] beat_adr_q, beat_adr_d;
  logic [ADR_WIDTH-1:0] nxt_adr, rd_adr;
  logic                 req, adr_oor, nxt_oor, wr_en;
  logic [SEL_W-1:0]     lane_we;

  assign req     = cyc_i & stb_i;
  assign nxt_adr = ADR_WIDTH'(next_adr(32'(beat_adr_q), bte_i));
  assign adr_oor = 32'(adr_i) >= 32'(MEM_SIZE);
  assign nxt_oor = 32'(nxt_adr) >= 32'(MEM_SIZE);
  assign wr_en   = req & we_i & ack_q & ~rst_i;
  assign lane_we = {SEL_W{wr_en}} & sel_i;

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    err_d      = err_q;
    beat_adr_d = beat_adr_q;
    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        err_d = 1'b0;
        if (req) begin
          beat_adr_d = adr_i;
          if (adr_oor) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = (cti_i == CTI_INCR) ? BURST : SINGLE;
            ack_d   = 1'b1;
          end
        end
      end
      SINGLE: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      BURST: begin
        if (!req || cti_i != CTI_INCR) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else if (nxt_oor) begin
          ack_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          beat_adr_d = nxt_adr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prefetch the next beat while bursting so data keeps up with a continuous ack.
  always_comb begin
    case (state_q)
      IDLE:    rd_adr = adr_i;
      BURST:   rd_adr = nxt_adr;
      default: rd_adr = beat_adr_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      beat_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      beat_adr_q <= beat_adr_d;
    end
  end

  ram_be #(
    .DAT_WIDTH(DAT_WIDTH),
    .ADR_WIDTH(ADR_WIDTH),
    .MEM_SIZE (MEM_SIZE)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rd_adr_i(rd_adr),
    .wr_adr_i(beat_adr_q),
    .we_i    (lane_we),
    .dat_i   (dat_i),
    .dat_o   (dat_o)
  );

  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_ram_wb_burst.sv
// Directed and randomized Wishbone burst traffic against a word-array reference model.
module tb_ram_wb_burst;

  localparam int MEM_WORDS = 1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [9:0]  adr_i = '0;
  logic        we_i  = 1'b0;
  logic [3:0]  sel_i = '0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [2:0]  cti_i = '0;
  logic [1:0]  bte_i = '0;
  logic        ack_o, err_o;

  ram_wb_burst #(.DAT_WIDTH(32), .ADR_WIDTH(10), .MEM_SIZE(MEM_WORDS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .dat_o(dat_o), .adr_i(adr_i),
    .we_i(we_i), .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .cti_i(cti_i),
    .bte_i(bte_i), .ack_o(ack_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [1024];
  logic [31:0] rd_log [$];
  logic [31:0] old8;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit on, input int a, input bit wr, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
    cyc_i = on; stb_i = on; adr_i = 10'(a); we_i = wr;
    dat_i = d; sel_i = s; cti_i = c; bte_i = b;
  endtask

  // Address sequence of a burst, straight from the burst-type definition.
  function automatic int ref_next(input int a, input logic [1:0] b);
    int k;
    k = (b == 2'b00) ? 0 : (2 << b);
    if (k == 0) return (a + 1) % 1024;
    return a - (a % k) + ((a % k) + 1) % k;
  endfunction

  function automatic logic [2:0] beat_cti(input int k, input int n);
    if (n == 1) return 3'b000;
    return (k == n - 1) ? 3'b111 : 3'b010;
  endfunction

  // One master access of n beats; optional one-cycle strobe gap or reset at a given beat.
  task automatic burst(input int start, input int n, input bit wr, input logic [1:0] b,
                       input logic [3:0] s, input logic [31:0] d0, input bit rnd,
                       input int gap_beat, input int rst_beat);
    int          adr [1024];
    logic [31:0] wd [1024];
    int          a, k;
    bit          gap_done;
    a = start;
    for (int i = 0; i < n; i++) begin
      adr[i] = a;
      wd[i]  = rnd ? $urandom : d0 + 32'(i);
      a      = ref_next(a, b);
    end
    drive(1, adr[0], wr, wd[0], s, beat_cti(0, n), b);
    tick();
    k = 0;
    gap_done = 0;
    while (k < n) begin
      if (adr[k] >= MEM_WORDS) begin
        chk("err_beat", {30'b0, err_o, ack_o}, 32'd2);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("err_clear", {30'b0, err_o, ack_o}, 32'd0);
        return;
      end
      chk("ack_beat", {30'b0, err_o, ack_o}, 32'd1);
      if (k == gap_beat && !gap_done) begin
        stb_i = 1'b0;
        tick();
        chk("gap_ack_low", {30'b0, err_o, ack_o}, 32'd0);
        drive(1, adr[k], wr, wd[k], s, (k == n - 1) ? 3'b111 : 3'b010, b);
        tick();
        gap_done = 1;
        continue;
      end
      if (!wr) begin
        chk("rd_dat", dat_o, model[adr[k]]);
        rd_log.push_back(dat_o);
      end
      if (k == rst_beat) begin
        rst_i = 1'b1;
        drive(1, adr[k], wr, wd[k], s, beat_cti(k, n), b);
        tick();
        chk("rst_ack", {30'b0, err_o, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        return;
      end
      if (wr) begin
        for (int l = 0; l < 4; l++) begin
          if (s[l]) model[adr[k]][8*l +: 8] = wd[k][8*l +: 8];
        end
      end
      drive(1, adr[k], wr, wd[k], s, beat_cti(k, n), b);
      tick();
      k++;
    end
    chk("ack_end", {30'b0, err_o, ack_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_ack", {31'b0, ack_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // Fill every word so later reads have defined contents.
    burst(0, MEM_WORDS, 1, 2'b00, 4'hF, 0, 1, -1, -1);

    burst(5, 1, 1, 2'b00, 4'hF, 32'hDEADBEEF, 0, -1, -1);
    rd_log.delete();
    burst(5, 1, 0, 2'b00, 4'hF, 0, 0, -1, -1);
    chk("classic_rd", rd_log[0], 32'hDEADBEEF);

    burst(20, 1, 1, 2'b00, 4'hF, 32'h11223344, 0, -1, -1);
    burst(20, 1, 1, 2'b00, 4'b0100, 32'hAABBCCDD, 0, -1, -1);
    rd_log.delete();
    burst(20, 1, 0, 2'b00, 4'hF, 0, 0, -1, -1);
    chk("byte_lane", rd_log[0], 32'h11BB3344);

    burst(8, 4, 0, 2'b00, 4'hF, 0, 0, -1, -1);

    old8 = model[8];
    burst(6, 4, 1, 2'b01, 4'hF, 32'd1, 0, -1, -1);
    rd_log.delete();
    burst(4, 5, 0, 2'b00, 4'hF, 0, 0, -1, -1);
    chk("wrap4_w4", rd_log[0], 32'd3);
    chk("wrap4_w5", rd_log[1], 32'd4);
    chk("wrap4_w6", rd_log[2], 32'd1);
    chk("wrap4_w7", rd_log[3], 32'd2);
    chk("wrap4_w8", rd_log[4], old8);

    burst(1000, 1, 0, 2'b00, 4'hF, 0, 0, -1, -1);
    burst(998, 3, 0, 2'b00, 4'hF, 0, 0, -1, -1);

    burst(100, 6, 1, 2'b00, 4'hF, 0, 1, 2, -1);
    burst(100, 7, 0, 2'b00, 4'hF, 0, 0, -1, -1);

    burst(200, 4, 1, 2'b00, 4'hF, 0, 1, -1, 2);
    burst(200, 4, 0, 2'b00, 4'hF, 0, 0, -1, -1);

    for (int i = 0; i < 60; i++) begin
      int          st, n;
      bit          wr;
      logic [1:0]  b;
      logic [3:0]  s;
      st = $urandom_range(0, 1010);
      n  = $urandom_range(1, 20);
      wr = 1'($urandom_range(0, 1));
      b  = 2'($urandom_range(0, 3));
      s  = 4'($urandom_range(0, 15));
      burst(st, n, wr, b, s, 0, 1, -1, -1);
      if (i % 3 == 0) tick();
    end

    // Read everything back once to catch stray writes anywhere.
    burst(0, MEM_WORDS, 0, 2'b00, 4'hF, 0, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
